// File: rtl/wr_admit_ctrl.sv
// Write-side admission stage: 2-entry skid buffer feeding the FIFO write pointer
// controller, plus registered fill level, almost-full flag and stall counter.
module wr_admit_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_LEN     = 8,
    parameter int AFULL_THRESH = 2**ADDR_LEN - 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid_i,
    input  logic [DATA_W-1:0]   s_data_i,
    output logic                s_ready_o,
    input  logic                wfull_i,
    output logic                wincr_o,
    output logic [DATA_W-1:0]   wdata_o,
    input  logic [ADDR_LEN:0]   wptr_i,
    input  logic [ADDR_LEN:0]   r2wptr_sync_i,
    output logic [ADDR_LEN:0]   wlevel_o,
    output logic                walmost_full_o,
    output logic [15:0]         wstall_cnt_o
);

    localparam int PTR_W = ADDR_LEN + 1;
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_TWO   = 2'd2
    } fill_t;

    fill_t             fill_q;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] skid_q;
    logic              out_valid;
    logic              accept;
    logic              drain;

    logic [PTR_W-1:0]  wbin;
    logic [PTR_W-1:0]  rbin;
    logic [PTR_W-1:0]  level_next;

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign out_valid = (fill_q != FILL_EMPTY);
    assign accept    = s_valid_i & s_ready_o;
    assign drain     = out_valid & ~wfull_i;
    assign wincr_o   = drain;
    assign wdata_o   = out_q;

    // Ready is registered from the next skid state, so wfull_i never reaches s_ready_o
    // combinationally; the skid entry absorbs the one word that slips in meanwhile.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            fill_q    <= FILL_EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            s_ready_o <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // branch below sees the pre-edge values of fill_q, out_q and skid_q.
            case (fill_q)
                FILL_EMPTY: begin
                    if (accept) begin
                        out_q  <= s_data_i;
                        fill_q <= FILL_ONE;
                    end
                end
                FILL_ONE: begin
                    if (accept && drain) begin
                        out_q <= s_data_i;
                    end else if (accept) begin
                        skid_q    <= s_data_i;
                        fill_q    <= FILL_TWO;
                        s_ready_o <= 1'b0;
                    end else if (drain) begin
                        fill_q <= FILL_EMPTY;
                    end
                end
                FILL_TWO: begin
                    if (drain) begin
                        out_q     <= skid_q;
                        fill_q    <= FILL_ONE;
                        s_ready_o <= 1'b1;
                    end
                end
                default: begin
                    fill_q    <= FILL_EMPTY;
                    s_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Modular subtraction keeps the level correct across pointer wrap.
    assign wbin       = gray2bin(wptr_i);
    assign rbin       = gray2bin(r2wptr_sync_i);
    assign level_next = wbin - rbin;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wlevel_o       <= '0;
            walmost_full_o <= 1'b0;
            wstall_cnt_o   <= '0;
        end else begin
            wlevel_o       <= level_next;
            walmost_full_o <= (level_next >= AFULL_LVL);
            if (out_valid && wfull_i && (wstall_cnt_o != 16'hFFFF)) begin
                wstall_cnt_o <= wstall_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wr_admit_ctrl.sv
// Self-checking bench for wr_admit_ctrl: directed steps plus random traffic compared
// against a queue-based model of the admission stage.
module tb_wr_admit_ctrl;

    localparam int DATA_W   = 8;
    localparam int ADDR_LEN = 8;
    localparam int PMASK    = (1 << (ADDR_LEN + 1)) - 1;
    localparam int AFULL    = (1 << ADDR_LEN) - 4;

    logic                wclk = 1'b0;
    logic                wrst_n;
    logic                s_valid_i;
    logic [DATA_W-1:0]   s_data_i;
    logic                s_ready_o;
    logic                wfull_i;
    logic                wincr_o;
    logic [DATA_W-1:0]   wdata_o;
    logic [ADDR_LEN:0]   wptr_i;
    logic [ADDR_LEN:0]   r2wptr_sync_i;
    logic [ADDR_LEN:0]   wlevel_o;
    logic                walmost_full_o;
    logic [15:0]         wstall_cnt_o;

    wr_admit_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_LEN    (ADDR_LEN),
        .AFULL_THRESH(AFULL)
    ) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_ready_o     (s_ready_o),
        .wfull_i       (wfull_i),
        .wincr_o       (wincr_o),
        .wdata_o       (wdata_o),
        .wptr_i        (wptr_i),
        .r2wptr_sync_i (r2wptr_sync_i),
        .wlevel_o      (wlevel_o),
        .walmost_full_o(walmost_full_o),
        .wstall_cnt_o  (wstall_cnt_o)
    );

    always #5 wclk = ~wclk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: words held by the stage, in arrival order.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] last_pop;
    logic              m_rdy;
    int                m_level;
    int                m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_LEN:0] to_gray(input int b);
        logic [ADDR_LEN:0] v;
        v = b[ADDR_LEN:0];
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        q.delete();
        last_pop = '0;
        m_rdy    = 1'b1;
        m_level  = 0;
        m_stall  = 0;
    endtask

    // One clock: drive inputs at negedge, check current outputs, then advance the model
    // to what the next rising edge produces.
    task automatic step(input logic rst, input logic vld, input logic [DATA_W-1:0] d,
                        input logic full, input int wb, input int rb);
        logic acc;
        logic drn;
        @(negedge wclk);
        wrst_n        = rst;
        s_valid_i     = vld;
        s_data_i      = d;
        wfull_i       = full;
        wptr_i        = to_gray(wb);
        r2wptr_sync_i = to_gray(rb);
        #1;
        check("s_ready", 32'(s_ready_o), 32'(m_rdy));
        check("wincr", 32'(wincr_o), 32'((q.size() > 0) && !full));
        check("wdata", 32'(wdata_o), 32'((q.size() > 0) ? q[0] : last_pop));
        check("wlevel", 32'(wlevel_o), 32'(m_level));
        check("walmost_full", 32'(walmost_full_o), 32'(m_level >= AFULL));
        check("wstall_cnt", 32'(wstall_cnt_o), 32'(m_stall));
        if (!rst) begin
            model_reset();
        end else begin
            acc = vld && m_rdy;
            drn = (q.size() > 0) && !full;
            if ((q.size() > 0) && full && (m_stall < 65535)) m_stall++;
            if (drn) last_pop = q.pop_front();
            if (acc) q.push_back(d);
            m_rdy   = (q.size() < 2);
            m_level = (wb - rb) & PMASK;
        end
    endtask

    initial begin
        int rb;
        int wb;
        wrst_n        = 1'b0;
        s_valid_i     = 1'b1;
        s_data_i      = 8'h77;
        wfull_i       = 1'b0;
        wptr_i        = '0;
        r2wptr_sync_i = '0;
        @(posedge wclk);
        #1;
        model_reset();

        // Reset held with valid asserted: nothing accepted.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h77, 1'b0, 0, 0);

        // Stream 0x01..0x05 back to back, then drain.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 0, 0);

        // Backpressure: A0 in out, A1 into skid while full, 10 stalled cycles, release.
        step(1'b1, 1'b1, 8'hA0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 8'hA1, 1'b1, 0, 0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 8'hA2, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 0, 0);

        // Level across wrap, full level and the almost-full threshold.
        step(1'b1, 1'b0, 8'h00, 1'b0, 5, 500);
        step(1'b1, 1'b0, 8'h00, 1'b0, 256, 0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 251, 0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 252, 0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 0, 0);

        // Random traffic and pointer pairs within the legal 0..depth range.
        for (int i = 0; i < 400; i++) begin
            rb = int'($urandom_range(0, PMASK));
            wb = (rb + int'($urandom_range(0, 1 << ADDR_LEN))) & PMASK;
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 3) == 0), wb, rb);
        end

        // Reset with both entries held: neither word may ever be written.
        step(1'b1, 1'b0, 8'h00, 1'b0, 0, 0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 0, 0);
        step(1'b1, 1'b1, 8'hB0, 1'b1, 40, 10);
        step(1'b1, 1'b1, 8'hB1, 1'b1, 40, 10);
        step(1'b1, 1'b1, 8'hB2, 1'b1, 40, 10);
        step(1'b0, 1'b0, 8'h00, 1'b1, 40, 10);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 0, 0);

        // Stall counter saturation: one word held under full past 16'hFFFF cycles.
        step(1'b1, 1'b1, 8'hC3, 1'b1, 0, 0);
        for (int i = 0; i < 65540; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 0, 0);
        check("stall_saturated", 32'(wstall_cnt_o), 32'h0000FFFF);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wr_admit_ctrl.md
Name: wr_admit_ctrl

Overview:
Write-side admission stage that sits directly upstream of the FIFO write pointer controller in the wclk domain. It converts an upstream valid/ready stream into the controller's wincr/wdata interface through a 2-entry skid buffer. The skid buffer keeps the registered full flag off the upstream ready path. It also derives a registered fill level, an almost-full flag and a saturating stall counter from the local Gray write pointer and the synchronized Gray read pointer.

Parameters:
DATA_W, 8, width of the data word
ADDR_LEN, 8, FIFO address width; pointers are ADDR_LEN+1 bits, depth 2**ADDR_LEN
AFULL_THRESH, 2**ADDR_LEN-4, fill level at or above which walmost_full_o asserts

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  reset, synchronous, active-low
s_valid_i  in  1  upstream word valid
s_data_i  in  DATA_W  upstream word
s_ready_o  out  1  upstream ready (registered)
wfull_i  in  1  registered full flag from write pointer controller
wincr_o  out  1  write request to write pointer controller and memory write enable
wdata_o  out  DATA_W  word to FIFO memory
wptr_i  in  ADDR_LEN+1  Gray write pointer from write pointer controller
r2wptr_sync_i  in  ADDR_LEN+1  Gray read pointer synchronized into wclk
wlevel_o  out  ADDR_LEN+1  registered fill level
walmost_full_o  out  1  registered level >= AFULL_THRESH
wstall_cnt_o  out  16  saturating count of cycles stalled by wfull_i

Behaviour:
- Single clock: wclk. Reset: wrst_n, synchronous and active-low, sampled only on the wclk rising edge.
- Reset values:
  - s_ready_o=1; out_valid=0; skid_valid=0.
  - wincr_o=0; wdata_o=0; wlevel_o=0; walmost_full_o=0; wstall_cnt_o=0.
  - Held words are discarded. Reset mid-operation behaves identically.
- Accept = s_valid_i & s_ready_o. Drain = wincr_o = out_valid & !wfull_i (combinational from out_valid and wfull_i). wdata_o = output register.
- Storage: output register (out) plus skid register (skid). Next-state rules, evaluated per edge:
  - EMPTY (out_valid=0, skid_valid=0): accept -> out<=s_data_i, out_valid<=1.
  - ONE (out_valid=1, skid_valid=0):
    - accept & drain -> out<=s_data_i.
    - accept & !drain -> skid<=s_data_i, skid_valid<=1.
    - !accept & drain -> out_valid<=0.
  - TWO (out_valid=1, skid_valid=1), no accept possible:
    - drain -> out<=skid, skid_valid<=0.
    - !drain -> hold.
- s_ready_o <= !(next skid_valid). It deasserts the cycle after a word enters skid and reasserts the cycle after skid empties.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Latency: a word accepted at edge N can drive wincr_o in cycle N+1.
- Full: with wfull_i=1, wincr_o=0 and out/skid hold. Words are never lost.
- Level arithmetic:
  - Convert wptr_i and r2wptr_sync_i to binary (b[ADDR_LEN]=g[ADDR_LEN], b[i]=b[i+1]^g[i]).
  - wlevel_o <= (wbin - rbin) modulo 2**(ADDR_LEN+1). Correct across pointer wrap.
  - The level is pessimistic because the read pointer is stale.
  - Range is 0..2**ADDR_LEN, and equals 2**ADDR_LEN exactly when full.
- walmost_full_o <= (wbin - rbin) >= AFULL_THRESH. It updates on the same edge as wlevel_o.
- wstall_cnt_o increments by 1 on each edge where out_valid & wfull_i. It saturates at 16'hFFFF and clears only on reset.

Test Plan:
- Reset then stream: hold wrst_n low 3 cycles with s_valid_i=1 -> s_ready_o=1, wincr_o=0, no accept. After release, words 0x01..0x05 on consecutive cycles with wfull_i=0 -> wincr_o high 5 cycles starting one cycle after first accept, wdata_o=0x01..0x05 in order.
- Backpressure: out holds 0xA0, assert wfull_i, present 0xA1 -> 0xA1 goes to skid, s_ready_o=0 next cycle. Hold wfull_i 10 cycles -> wstall_cnt_o=10, no wincr_o. Release -> wincr_o with 0xA0 then 0xA1, s_ready_o=1 one cycle after skid drains.
- Level wrap: ADDR_LEN=8, wptr_i=Gray(5), r2wptr_sync_i=Gray(500) -> wlevel_o=17 next cycle.
- Full level: wptr_i=Gray(256), r2wptr_sync_i=Gray(0) -> wlevel_o=256, walmost_full_o=1. With wptr_i=Gray(251) -> walmost_full_o=0; with Gray(252) -> walmost_full_o=1.
- Saturation: force wstall_cnt_o to 16'hFFFE, keep stalled 3 cycles -> wstall_cnt_o=16'hFFFF and holds.
- Reset mid-operation: out and skid both full (s_ready_o=0), pulse wrst_n low 1 cycle -> next cycle s_ready_o=1, wincr_o=0, wlevel_o=0. Neither held word is ever written.
